// File: rtl/rom_access_arbiter.sv
// Single-port image ROM arbiter: display reads always win the issue slot, a
// background burst reader fills idle slots, and returned words are routed by tag.
module rom_access_arbiter #(
  parameter int ROM_ADDR_BUS_WIDTH = 17,
  parameter int DATA_WIDTH         = 24,
  parameter int ROM_LATENCY        = 2,
  parameter int LEN_WIDTH          = 8,
  parameter int STARVE_LIMIT       = 64
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          DISP_REQ,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] DISP_ADDR,
  output logic [DATA_WIDTH-1:0]         DISP_DATA,
  output logic                          DISP_VALID,
  input  logic                          AUX_START,
  input  logic [ROM_ADDR_BUS_WIDTH-1:0] AUX_BASE,
  input  logic [LEN_WIDTH-1:0]          AUX_LEN,
  output logic                          AUX_BUSY,
  output logic [DATA_WIDTH-1:0]         AUX_DATA,
  output logic                          AUX_VALID,
  output logic                          AUX_DONE,
  output logic                          AUX_STARVED,
  output logic [ROM_ADDR_BUS_WIDTH-1:0] ROM_ADDR,
  input  logic [DATA_WIDTH-1:0]         ROM_Q
);

  localparam int SC_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_WIDTH-1:0] STARVE_MAX = SC_WIDTH'(STARVE_LIMIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]                    state_r;
  logic [ROM_ADDR_BUS_WIDTH-1:0] base_r;
  logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr_r;
  logic [ROM_ADDR_BUS_WIDTH-1:0] rom_addr_s;
  logic [LEN_WIDTH-1:0]          len_r;
  logic [LEN_WIDTH-1:0]          issued_r;
  logic [LEN_WIDTH-1:0]          returned_r;
  logic [ROM_LATENCY-1:0]        tag_disp_r;
  logic [ROM_LATENCY-1:0]        tag_aux_r;
  logic [SC_WIDTH-1:0]           starve_cnt_r;
  logic                          starved_r;
  logic                          aux_busy_r;
  logic                          aux_done_r;
  logic                          disp_valid_r;
  logic                          aux_valid_r;
  logic [DATA_WIDTH-1:0]         disp_data_r;
  logic [DATA_WIDTH-1:0]         aux_data_r;

  logic accept_s;
  logic aux_issue_s;
  logic denied_s;
  logic ret_disp_s;
  logic ret_aux_s;

  assign accept_s    = (state_r == ST_IDLE) && AUX_START && (AUX_LEN != '0);
  assign aux_issue_s = (state_r == ST_BURST) && !DISP_REQ;
  assign denied_s    = (state_r == ST_BURST) && DISP_REQ;
  assign ret_disp_s  = tag_disp_r[ROM_LATENCY-1];
  assign ret_aux_s   = tag_aux_r[ROM_LATENCY-1];

  // Issue-slot address mux; ROM_ADDR must show the winner in the same cycle.
  always_comb begin
    rom_addr_s = rom_addr_r;
    if (RESET) begin
      rom_addr_s = '0;
    end else if (DISP_REQ) begin
      rom_addr_s = DISP_ADDR;
    end else if (state_r == ST_BURST) begin
      rom_addr_s = base_r + ROM_ADDR_BUS_WIDTH'(issued_r);
    end else begin
      rom_addr_s = rom_addr_r;
    end
  end

  // Burst FSM with issue/return counters and the BUSY/DONE flags.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      base_r     <= '0;
      len_r      <= '0;
      issued_r   <= '0;
      returned_r <= '0;
      rom_addr_r <= '0;
      aux_busy_r <= 1'b0;
      aux_done_r <= 1'b0;
    end else begin
      rom_addr_r <= rom_addr_s;
      aux_done_r <= 1'b0;
      if (accept_s) begin
        returned_r <= '0;
      end else if (ret_aux_s) begin
        returned_r <= returned_r + LEN_WIDTH'(1);
      end else begin
        returned_r <= returned_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_BURST;
            base_r     <= AUX_BASE;
            len_r      <= AUX_LEN;
            issued_r   <= '0;
            aux_busy_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (aux_issue_s) begin
            issued_r <= issued_r + LEN_WIDTH'(1);
            if ((issued_r + LEN_WIDTH'(1)) == len_r) begin
              state_r <= ST_DRAIN;
            end else begin
              state_r <= ST_BURST;
            end
          end else begin
            state_r <= ST_BURST;
          end
        end
        ST_DRAIN: begin
          if (returned_r == len_r) begin
            state_r    <= ST_IDLE;
            aux_done_r <= 1'b1;
            aux_busy_r <= 1'b0;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          aux_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Requester tags travel alongside the ROM read so returns can be routed.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      tag_disp_r <= '0;
      tag_aux_r  <= '0;
    end else begin
      tag_disp_r[0] <= DISP_REQ;
      tag_aux_r[0]  <= aux_issue_s;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        tag_disp_r[i] <= tag_disp_r[i-1];
        tag_aux_r[i]  <= tag_aux_r[i-1];
      end
    end
  end

  // Return path: capture ROM_Q for whichever requester owns this slot.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      disp_valid_r <= 1'b0;
      aux_valid_r  <= 1'b0;
      disp_data_r  <= '0;
      aux_data_r   <= '0;
    end else begin
      disp_valid_r <= ret_disp_s;
      aux_valid_r  <= ret_aux_s;
      if (ret_disp_s) begin
        disp_data_r <= ROM_Q;
      end else begin
        disp_data_r <= disp_data_r;
      end
      if (ret_aux_s) begin
        aux_data_r <= ROM_Q;
      end else begin
        aux_data_r <= aux_data_r;
      end
    end
  end

  // Starvation: count consecutive denied burst cycles; the flag is sticky until the next burst.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      starve_cnt_r <= '0;
      starved_r    <= 1'b0;
    end else if (accept_s) begin
      starve_cnt_r <= '0;
      starved_r    <= 1'b0;
    end else if (denied_s) begin
      if (starve_cnt_r != STARVE_MAX) begin
        starve_cnt_r <= starve_cnt_r + SC_WIDTH'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
      if (starve_cnt_r >= (STARVE_MAX - SC_WIDTH'(1))) begin
        starved_r <= 1'b1;
      end else begin
        starved_r <= starved_r;
      end
    end else if (aux_issue_s) begin
      starve_cnt_r <= '0;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign ROM_ADDR    = rom_addr_s;
  assign DISP_DATA   = disp_data_r;
  assign DISP_VALID  = disp_valid_r;
  assign AUX_DATA    = aux_data_r;
  assign AUX_VALID   = aux_valid_r;
  assign AUX_BUSY    = aux_busy_r;
  assign AUX_DONE    = aux_done_r;
  assign AUX_STARVED = starved_r;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Randomised scoreboard bench for rom_access_arbiter: the driver predicts each
// issue slot and queues the expected return; a negedge monitor pops and compares.
module tb_rom_access_arbiter;

  localparam int AW = 17;
  localparam int DW = 24;
  localparam int L  = 2;
  localparam int LW = 8;
  localparam int SL = 64;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic          DISP_REQ;
  logic [AW-1:0] DISP_ADDR;
  logic [DW-1:0] DISP_DATA;
  logic          DISP_VALID;
  logic          AUX_START;
  logic [AW-1:0] AUX_BASE;
  logic [LW-1:0] AUX_LEN;
  logic          AUX_BUSY;
  logic [DW-1:0] AUX_DATA;
  logic          AUX_VALID;
  logic          AUX_DONE;
  logic          AUX_STARVED;
  logic [AW-1:0] ROM_ADDR;
  logic [DW-1:0] ROM_Q;

  rom_access_arbiter #(
    .ROM_ADDR_BUS_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(L),
    .LEN_WIDTH(LW), .STARVE_LIMIT(SL)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .DISP_REQ(DISP_REQ), .DISP_ADDR(DISP_ADDR), .DISP_DATA(DISP_DATA), .DISP_VALID(DISP_VALID),
    .AUX_START(AUX_START), .AUX_BASE(AUX_BASE), .AUX_LEN(AUX_LEN), .AUX_BUSY(AUX_BUSY),
    .AUX_DATA(AUX_DATA), .AUX_VALID(AUX_VALID), .AUX_DONE(AUX_DONE), .AUX_STARVED(AUX_STARVED),
    .ROM_ADDR(ROM_ADDR), .ROM_Q(ROM_Q)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return DW'(a) * 24'd3;
  endfunction

  // ROM with fixed read latency L
  logic [AW-1:0] rp [L];
  always @(posedge CLOCK) begin
    rp[0] <= ROM_ADDR;
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign ROM_Q = rom_fn(rp[L-1]);

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            last;
  } exp_t;

  exp_t dq[$];
  exp_t aq[$];

  bit            m_busy, m_issuing, m_starved;
  logic [AW-1:0] m_base, m_last;
  int            m_len, m_issued, m_starve;
  int            done_cycle = -1;
  int            last_done = -1;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus; entered and left at 1 time unit after a posedge.
  task automatic cycle(input bit dreq, input logic [AW-1:0] daddr, input bit st,
                       input logic [AW-1:0] base, input int len);
    bit            accept, starve_next;
    logic [AW-1:0] ea;
    DISP_REQ  = dreq;
    DISP_ADDR = daddr;
    AUX_START = st;
    AUX_BASE  = base;
    AUX_LEN   = LW'(len);
    accept = st && (len != 0) && (!m_busy || cyc == done_cycle);
    starve_next = 1'b0;
    if (dreq) begin
      ea = daddr;
      dq.push_back('{data: rom_fn(daddr), cyc: cyc + L + 1, last: 1'b0});
      if (m_issuing) begin
        if (m_starve < SL) m_starve++;
        if (m_starve == SL) starve_next = 1'b1;
      end
    end else if (m_issuing) begin
      ea = m_base + AW'(m_issued);
      aq.push_back('{data: rom_fn(ea), cyc: cyc + L + 1, last: (m_issued + 1 == m_len)});
      m_issued++;
      m_starve = 0;
      if (m_issued == m_len) m_issuing = 1'b0;
    end else begin
      ea = m_last;
    end
    m_last = ea;
    #1;
    check("rom_addr", 64'(ROM_ADDR), 64'(ea));
    @(posedge CLOCK);
    if (accept) begin
      m_busy = 1'b1; m_issuing = 1'b1; m_base = base; m_len = len;
      m_issued = 0; m_starve = 0; m_starved = 1'b0;
    end
    if (starve_next) m_starved = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1; DISP_REQ = 1'b0; AUX_START = 1'b0;
    dq.delete(); aq.delete();
    m_busy = 1'b0; m_issuing = 1'b0; m_starved = 1'b0; m_starve = 0;
    m_last = '0; done_cycle = -1;
    #1;
    check("rst_disp_valid", 64'(DISP_VALID), 64'd0);
    check("rst_disp_data", 64'(DISP_DATA), 64'd0);
    check("rst_aux_valid", 64'(AUX_VALID), 64'd0);
    check("rst_aux_data", 64'(AUX_DATA), 64'd0);
    check("rst_aux_busy", 64'(AUX_BUSY), 64'd0);
    check("rst_aux_done", 64'(AUX_DONE), 64'd0);
    check("rst_starved", 64'(AUX_STARVED), 64'd0);
    check("rst_rom_addr", 64'(ROM_ADDR), 64'd0);
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
  endtask

  // Monitor: every returned word must match the oldest queued expectation in value and cycle.
  initial begin
    bit exp_v, exp_done;
    forever begin
      @(negedge CLOCK);
      if (!RESET) begin
        check("both_valid", 64'(DISP_VALID & AUX_VALID), 64'd0);
        exp_v = (dq.size() > 0) && (dq[0].cyc == cyc);
        check("disp_valid", 64'(DISP_VALID), 64'(exp_v));
        if (exp_v) begin
          check("disp_data", 64'(DISP_DATA), 64'(dq[0].data));
          void'(dq.pop_front());
        end
        exp_v = (aq.size() > 0) && (aq[0].cyc == cyc);
        check("aux_valid", 64'(AUX_VALID), 64'(exp_v));
        if (exp_v) begin
          check("aux_data", 64'(AUX_DATA), 64'(aq[0].data));
          if (aq[0].last) done_cycle = cyc + 1;
          void'(aq.pop_front());
        end
        exp_done = (cyc == done_cycle);
        if (exp_done) m_busy = 1'b0;
        if (AUX_DONE) last_done = cyc;
        check("aux_done", 64'(AUX_DONE), 64'(exp_done));
        check("aux_busy", 64'(AUX_BUSY), 64'(m_busy));
        check("aux_starved", 64'(AUX_STARVED), 64'(m_starved));
      end
    end
  end

  initial begin
    int s;
    RESET = 1'b1; DISP_REQ = 1'b0; DISP_ADDR = '0;
    AUX_START = 1'b0; AUX_BASE = '0; AUX_LEN = '0;
    @(posedge CLOCK);
    #1;
    do_reset();
    idle(2);

    // display only, addresses 0..9
    for (int i = 0; i < 10; i++) cycle(1'b1, AW'(i), 1'b0, '0, 0);
    idle(6);

    // idle burst of 4 at 0x1000
    s = cyc;
    cycle(1'b0, '0, 1'b1, 17'h01000, 4);
    idle(10);
    check("idle_burst_done_at", 64'(last_done - s), 64'd8);

    // burst of 16 with display toggling every cycle
    cycle(1'b0, '0, 1'b1, 17'h02000, 16);
    for (int i = 0; i < 40; i++) cycle(i[0], AW'($urandom), 1'b0, '0, 0);
    idle(8);

    // address wrap, then zero-length start
    cycle(1'b0, '0, 1'b1, 17'h1FFFE, 3);
    idle(8);
    s = last_done;
    cycle(1'b0, '0, 1'b1, 17'h00500, 0);
    idle(6);
    check("zero_len_no_done", 64'(last_done), 64'(s));

    // starvation with a second start while busy
    cycle(1'b1, AW'($urandom), 1'b1, 17'h04000, 2);
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, AW'($urandom), (i == 50), 17'h07000, 5);
      if (i == 62) check("starve_before_64", 64'(AUX_STARVED), 64'd0);
      if (i == 63) check("starve_at_64", 64'(AUX_STARVED), 64'd1);
    end
    idle(8);
    check("starve_sticky", 64'(AUX_STARVED), 64'd1);
    check("starve_burst_idle", 64'(AUX_BUSY), 64'd0);

    // random mixed traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), AW'($urandom), ($urandom_range(0, 7) == 0),
            AW'($urandom), $urandom_range(0, 12));
    idle(30);

    // reset with aux reads in flight, then a fresh burst
    cycle(1'b0, '0, 1'b1, 17'h06000, 8);
    idle(3);
    s = last_done;
    do_reset();
    idle(8);
    check("no_done_after_reset", 64'(last_done), 64'(s));
    cycle(1'b0, '0, 1'b1, 17'h00100, 3);
    idle(10);

    check("disp_queue_drained", 64'(dq.size()), 64'd0);
    check("aux_queue_drained", 64'(aq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Arbitrates the single-port product image ROM between the real-time pixel fetch path and a background burst reader. The burst reader loads basket thumbnails and digit glyphs into line caches. The block sits between the pixel controller and the image ROM in the VGA clock domain. Display reads always win, and burst reads fill only the cycles the display leaves idle. Returned data is tagged and routed back to the requester that issued the address.

## Interface
- ROM_ADDR_BUS_WIDTH, 17, image ROM address width (100x100x12 words).
- DATA_WIDTH, 24, ROM word width ({B,G,R}, 8 bits each).
- ROM_LATENCY, 2, fixed ROM read latency in cycles, ≥1.
- LEN_WIDTH, 8, burst length field width.
- STARVE_LIMIT, 64, consecutive denied cycles before the starvation flag sets.

Ports:
- CLOCK  in  1  VGA pixel clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- DISP_REQ  in  1  display read request, sampled every cycle.
- DISP_ADDR  in  ROM_ADDR_BUS_WIDTH  display read address.
- DISP_DATA  out  DATA_WIDTH  display read data.
- DISP_VALID  out  1  DISP_DATA valid, one cycle per request.
- AUX_START  in  1  start burst; sampled only in IDLE.
- AUX_BASE  in  ROM_ADDR_BUS_WIDTH  burst start address.
- AUX_LEN  in  LEN_WIDTH  burst word count; 0 means no transfer.
- AUX_BUSY  out  1  burst accepted and not yet complete.
- AUX_DATA  out  DATA_WIDTH  burst read data.
- AUX_VALID  out  1  AUX_DATA valid.
- AUX_DONE  out  1  one-cycle pulse after the last burst word is delivered.
- AUX_STARVED  out  1  sticky starvation flag.
- ROM_ADDR  out  ROM_ADDR_BUS_WIDTH  address to the ROM.
- ROM_Q  in  DATA_WIDTH  ROM data; corresponds to ROM_ADDR from ROM_LATENCY cycles earlier.

## Operation
- Issue slot (each cycle):
  - DISP_REQ=1: ROM_ADDR=DISP_ADDR, and tag DISP is pushed.
  - Else, in BURST: ROM_ADDR=AUX_BASE_q+issued, issued++, and tag AUX is pushed.
  - Else: ROM_ADDR holds its last value, and tag NONE is pushed.
- ROM_ADDR is registered in the cycle it is decided and presented combinationally. It must equal the chosen address in the same cycle.
- Tag pipeline: a ROM_LATENCY-deep shift register of {disp,aux}.
  - When the output tag is DISP, register ROM_Q into DISP_DATA and pulse DISP_VALID.
  - When the output tag is AUX, register ROM_Q into AUX_DATA, pulse AUX_VALID, and increment returned.
  - The data registers hold their value when not valid.
- FSM states:
  - IDLE → BURST when AUX_START=1 and AUX_LEN≠0. Capture AUX_BASE and AUX_LEN, clear issued, returned and AUX_STARVED, set AUX_BUSY. AUX_START with AUX_LEN=0 is ignored: no BUSY, no DONE.
  - BURST → DRAIN in the cycle issued reaches len_q, after the last issue.
  - DRAIN → IDLE when returned==len_q. AUX_DONE pulses for one cycle, coincident with the IDLE entry cycle; AUX_BUSY clears in the same cycle.
- AUX_START while BUSY is ignored. No queueing.
- Arithmetic: the burst address is AUX_BASE_q+issued modulo 2^ROM_ADDR_BUS_WIDTH, so it wraps silently. The issued and returned counters are LEN_WIDTH bits wide.
- Starvation: a cycle counter increments on every BURST cycle with DISP_REQ=1 and clears on any aux issue. When it reaches STARVE_LIMIT, AUX_STARVED sets. The flag stays set until the next accepted AUX_START. The arbiter still never stalls display.

## Timing
- Display latency: DISP_VALID rises ROM_LATENCY+1 cycles after the edge sampling DISP_REQ=1. That is 3 cycles at default. Throughput is one read per cycle.
- Aux latency: the first AUX_VALID comes no earlier than ROM_LATENCY+2 cycles after AUX_START is sampled. The start takes one cycle to enter BURST.
- Burst length: the minimum from AUX_START to AUX_DONE is len+ROM_LATENCY+2 cycles, with no display traffic.
- DISP_VALID and AUX_VALID are never high in the same cycle.
- Reset values: all outputs 0, and the FSM is in IDLE.
  - Tags, counters and the starvation flag clear.
  - In-flight reads are discarded, and no VALID is produced from pre-reset issues.
  - A reset mid-burst produces no AUX_DONE.

## Test plan
- Display only: DISP_REQ=1 with addresses 0,1,2,…,9 over 10 cycles, ROM model returning addr×3 → DISP_VALID for 10 consecutive cycles starting cycle 3, data 0,3,…,27; AUX_VALID stays 0.
- Idle burst: AUX_START, AUX_BASE=0x1000, AUX_LEN=4, no display traffic → ROM_ADDR 0x1000–0x1003 on consecutive cycles; 4 AUX_VALID pulses in order; AUX_DONE at cycle 8; BUSY high cycles 1–7.
- Interleave: burst of 16 while DISP_REQ toggles every cycle → all 16 aux words and every display word delivered in issue order; display latency is always 3 cycles.
- Wrap and zero length:
  - AUX_BASE=0x1FFFE, LEN=3 → addresses 0x1FFFE, 0x1FFFF, 0x00000.
  - LEN=0 → BUSY and DONE never assert.
- Starvation and ignored start: DISP_REQ held high for 100 cycles during a LEN=2 burst → AUX_STARVED sets at denied cycle 64. Then DISP_REQ drops → burst completes with DONE and the flag stays set. A second AUX_START issued while BUSY is ignored.
- Reset mid-burst: assert RESET with 2 aux reads in flight → all outputs 0 immediately. After release, no stray AUX_VALID or DONE, and a new burst works.
